// File: rtl/fp_i2f_seq.sv
// Multi-cycle INT32 -> FP32 converter: shift-based normaliser followed by a single IEEE-754
// rounding cycle. One operation in flight; result held until consumed.
module fp_i2f_seq #(
    parameter int unsigned NORM_STEP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] operand_i,
    input  logic        signed_i,
    input  logic [2:0]  rnd_i,
    input  logic [2:0]  frm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic [4:0]  flags_o
);

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    localparam logic [2:0] RmRne = 3'd0;
    localparam logic [2:0] RmRtz = 3'd1;
    localparam logic [2:0] RmRdn = 3'd2;
    localparam logic [2:0] RmRup = 3'd3;
    localparam logic [2:0] RmRmm = 3'd4;
    localparam logic [2:0] RmDyn = 3'd7;

    state_e      state_q, state_d;
    logic        sign_q, sign_d;
    logic [31:0] mag_q, mag_d;
    logic [7:0]  exp_q, exp_d;
    logic [2:0]  rm_q, rm_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  flags_q, flags_d;

    logic        accept;
    logic [2:0]  rm_res;
    logic        op_neg;
    logic [31:0] op_mag;
    logic [22:0] man, man_rnd;
    logic        g_bit, s_bit, round_up, carry;
    logic [7:0]  exp_rnd;

    assign in_ready_o  = rst_n & (state_q == StIdle) & ~flush_i;
    assign out_valid_o = (state_q == StDone);
    assign result_o    = result_q;
    assign flags_o     = flags_q;

    assign accept = in_valid_i & in_ready_o;
    assign rm_res = (rnd_i == RmDyn) ? frm_i : rnd_i;
    assign op_neg = signed_i & operand_i[31];
    // INT_MIN negates to itself, which is exactly its magnitude as unsigned
    assign op_mag = op_neg ? (~operand_i + 32'd1) : operand_i;

    assign man   = mag_q[30:8];
    assign g_bit = mag_q[7];
    assign s_bit = |mag_q[6:0];

    always_comb begin
        round_up = 1'b0;
        case (rm_q)
            RmRne:   round_up = g_bit & (s_bit | man[0]);
            RmRtz:   round_up = 1'b0;
            RmRdn:   round_up = sign_q & (g_bit | s_bit);
            RmRup:   round_up = ~sign_q & (g_bit | s_bit);
            RmRmm:   round_up = g_bit;
            default: round_up = 1'b0;
        endcase
    end

    assign {carry, man_rnd} = {1'b0, man} + {23'd0, round_up};
    assign exp_rnd          = exp_q + {7'd0, carry};

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        rm_d     = rm_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    sign_d = op_neg;
                    mag_d  = op_mag;
                    exp_d  = 8'd158;
                    rm_d   = rm_res;
                    if (operand_i == 32'd0) begin
                        result_d = 32'h0000_0000;
                        flags_d  = 5'b00000;
                        state_d  = StDone;
                    end else if (rm_res > RmRmm) begin
                        result_d = 32'h7FC0_0000;
                        flags_d  = 5'b10000;
                        state_d  = StDone;
                    end else if (op_mag[31]) begin
                        state_d = StRound;
                    end else begin
                        state_d = StNorm;
                    end
                end
            end
            StNorm: begin
                // Look ahead at the shifted value so the last shift lands directly in ROUND
                if (mag_q[31]) begin
                    state_d = StRound;
                end else begin
                    if (mag_q[31 -: NORM_STEP] == '0) begin
                        mag_d = mag_q << NORM_STEP;
                        exp_d = exp_q - 8'(NORM_STEP);
                    end else begin
                        mag_d = mag_q << 1;
                        exp_d = exp_q - 8'd1;
                    end
                    if (mag_d[31]) begin
                        state_d = StRound;
                    end
                end
            end
            StRound: begin
                result_d = {sign_q, exp_rnd, man_rnd};
                flags_d  = {4'b0000, g_bit | s_bit};
                state_d  = StDone;
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            mag_q    <= 32'd0;
            exp_q    <= 8'd0;
            rm_q     <= 3'd0;
            result_q <= 32'd0;
            flags_q  <= 5'd0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            rm_q     <= rm_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_fp_i2f_seq.sv
// Directed bench for fp_i2f_seq: one DUT with NORM_STEP=1 plus a NORM_STEP=8 instance on
// the same stimulus to compare results and normaliser latency.
module tb_fp_i2f_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [31:0] operand_i = 32'd0;
    logic        signed_i = 1'b0;
    logic [2:0]  rnd_i = 3'd0;
    logic [2:0]  frm_i = 3'd0;
    logic        out_ready_i = 1'b0;

    logic        in_ready_o, out_valid_o;
    logic [31:0] result_o;
    logic [4:0]  flags_o;
    logic        in_ready8, out_valid8;
    logic [31:0] result8;
    logic [4:0]  flags8;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fp_i2f_seq #(.NORM_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .operand_i(operand_i), .signed_i(signed_i), .rnd_i(rnd_i),
        .frm_i(frm_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .flags_o(flags_o)
    );

    fp_i2f_seq #(.NORM_STEP(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready8), .operand_i(operand_i), .signed_i(signed_i), .rnd_i(rnd_i),
        .frm_i(frm_i), .out_valid_o(out_valid8), .out_ready_i(out_ready_i),
        .result_o(result8), .flags_o(flags8)
    );

    // Launches one op with out_ready_i=1 and records each DUT's first valid result and latency
    task automatic run_op(input logic [31:0] op, input logic sgn, input logic [2:0] rnd,
                          input logic [2:0] frm, output logic [31:0] res, output logic [4:0] flg,
                          output int lat, output logic [31:0] res8, output int lat8);
        @(negedge clk);
        operand_i   = op;
        signed_i    = sgn;
        rnd_i       = rnd;
        frm_i       = frm;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        res = 32'hDEAD_BEEF; flg = 5'h1F; res8 = 32'hDEAD_BEEF;
        lat = -1; lat8 = -1;
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        for (int n = 1; n <= 60 && (lat < 0 || lat8 < 0); n++) begin
            if (out_valid_o && lat < 0) begin
                lat = n; res = result_o; flg = flags_o;
            end
            if (out_valid8 && lat8 < 0) begin
                lat8 = n; res8 = result8;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_total++;
        if (in_ready_o !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", in_ready_o);
        else n_pass++;
        n_total++;
        if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid_o);
        else n_pass++;
        n_total++;
        if (result_o !== 32'd0) $display("FAIL reset_result got=%h want=0", result_o);
        else n_pass++;
        n_total++;
        if (flags_o !== 5'd0) $display("FAIL reset_flags got=%b want=0", flags_o);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (in_ready_o !== 1'b1) $display("FAIL idle_in_ready got=%b want=1", in_ready_o);
        else n_pass++;
    endtask

    task automatic test_one();
        logic [31:0] r, r8; logic [4:0] f; int l, l8;
        run_op(32'd1, 1'b1, 3'd0, 3'd0, r, f, l, r8, l8);
        n_total++;
        if (r !== 32'h3F80_0000) $display("FAIL one_result got=%h want=3f800000", r);
        else n_pass++;
        n_total++;
        if (f !== 5'd0) $display("FAIL one_flags got=%b want=00000", f);
        else n_pass++;
        n_total++;
        if (l !== 33) $display("FAIL one_latency got=%0d want=33", l);
        else n_pass++;
        n_total++;
        if (r8 !== 32'h3F80_0000) $display("FAIL one_result_step8 got=%h want=3f800000", r8);
        else n_pass++;
        // Step 8: three byte shifts then seven single shifts = 10 steps
        n_total++;
        if (l8 !== 12) $display("FAIL one_latency_step8 got=%0d want=12", l8);
        else n_pass++;
    endtask

    task automatic test_signed();
        logic [31:0] r, r8; logic [4:0] f; int l, l8;
        run_op(32'hFFFF_FFFF, 1'b1, 3'd0, 3'd0, r, f, l, r8, l8);
        n_total++;
        if (r !== 32'hBF80_0000 || f !== 5'd0)
            $display("FAIL neg_one got=%h/%b want=bf800000/00000", r, f);
        else n_pass++;
        run_op(32'h8000_0000, 1'b1, 3'd0, 3'd0, r, f, l, r8, l8);
        n_total++;
        if (r !== 32'hCF00_0000 || f !== 5'd0)
            $display("FAIL int_min got=%h/%b want=cf000000/00000", r, f);
        else n_pass++;
        run_op(32'h7FFF_FFFF, 1'b1, 3'd0, 3'd0, r, f, l, r8, l8);
        n_total++;
        if (r !== 32'h4F00_0000 || f !== 5'b00001)
            $display("FAIL int_max got=%h/%b want=4f000000/00001", r, f);
        else n_pass++;
    endtask

    task automatic test_unsigned();
        logic [31:0] r, r8; logic [4:0] f; int l, l8;
        run_op(32'hFFFF_FFFF, 1'b0, 3'd1, 3'd0, r, f, l, r8, l8);
        n_total++;
        if (r !== 32'h4F7F_FFFF || f !== 5'b00001)
            $display("FAIL umax_rtz got=%h/%b want=4f7fffff/00001", r, f);
        else n_pass++;
        run_op(32'hFFFF_FFFF, 1'b0, 3'd0, 3'd0, r, f, l, r8, l8);
        n_total++;
        if (r !== 32'h4F80_0000 || f !== 5'b00001)
            $display("FAIL umax_rne got=%h/%b want=4f800000/00001", r, f);
        else n_pass++;
        n_total++;
        if (l !== 2) $display("FAIL umax_latency got=%0d want=2", l);
        else n_pass++;
    endtask

    task automatic test_rounding();
        logic [31:0] r, r8; logic [4:0] f; int l, l8;
        run_op(32'h0100_0001, 1'b0, 3'd0, 3'd0, r, f, l, r8, l8);
        n_total++;
        if (r !== 32'h4B80_0000 || f !== 5'b00001)
            $display("FAIL tie_rne got=%h/%b want=4b800000/00001", r, f);
        else n_pass++;
        run_op(32'h0100_0001, 1'b0, 3'd3, 3'd0, r, f, l, r8, l8);
        n_total++;
        if (r !== 32'h4B80_0001 || f !== 5'b00001)
            $display("FAIL tie_rup got=%h/%b want=4b800001/00001", r, f);
        else n_pass++;
        run_op(32'h0100_0003, 1'b0, 3'd4, 3'd0, r, f, l, r8, l8);
        n_total++;
        if (r !== 32'h4B80_0002 || f !== 5'b00001)
            $display("FAIL tie_rmm got=%h/%b want=4b800002/00001", r, f);
        else n_pass++;
    endtask

    task automatic test_dyn_and_special();
        logic [31:0] r, r8; logic [4:0] f; int l, l8;
        run_op(32'hFFFF_FFFD, 1'b1, 3'd7, 3'd2, r, f, l, r8, l8);
        n_total++;
        if (r !== 32'hC040_0000 || f !== 5'd0)
            $display("FAIL dyn_rdn got=%h/%b want=c0400000/00000", r, f);
        else n_pass++;
        run_op(32'hFFFF_FFFD, 1'b1, 3'd7, 3'b101, r, f, l, r8, l8);
        n_total++;
        if (r !== 32'h7FC0_0000 || f !== 5'b10000)
            $display("FAIL dyn_invalid got=%h/%b want=7fc00000/10000", r, f);
        else n_pass++;
        n_total++;
        if (l !== 1) $display("FAIL invalid_latency got=%0d want=1", l);
        else n_pass++;
        run_op(32'd0, 1'b1, 3'd2, 3'd0, r, f, l, r8, l8);
        n_total++;
        if (r !== 32'd0 || f !== 5'd0) $display("FAIL zero got=%h/%b want=00000000/00000", r, f);
        else n_pass++;
        n_total++;
        if (l !== 1) $display("FAIL zero_latency got=%0d want=1", l);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int waited = 0;
        @(negedge clk);
        operand_i = 32'hFFFF_FFFF; signed_i = 1'b0; rnd_i = 3'd0; out_ready_i = 1'b0;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        while (!out_valid_o && waited < 10) begin
            @(posedge clk);
            #1 waited++;
        end
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (out_valid_o !== 1'b1 || result_o !== 32'h4F80_0000 || in_ready_o !== 1'b0)
                $display("FAIL hold_%0d got=%b/%h/%b want=1/4f800000/0", i, out_valid_o,
                         result_o, in_ready_o);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1)
            $display("FAIL release got=%b/%b want=0/1", out_valid_o, in_ready_o);
        else n_pass++;
    endtask

    task automatic test_flush();
        int seen = 0;
        @(negedge clk);
        operand_i = 32'd1; signed_i = 1'b1; rnd_i = 3'd0; out_ready_i = 1'b1;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        n_total++;
        if (in_ready_o !== 1'b0) $display("FAIL flush_ready got=%b want=0", in_ready_o);
        else n_pass++;
        @(posedge clk);
        #1 flush_i = 1'b0;
        #1;
        n_total++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1)
            $display("FAIL flush_idle got=%b/%b want=0/1", out_valid_o, in_ready_o);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (out_valid_o) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL flush_no_result got=%0d want=0", seen);
        else n_pass++;
        // Flush in the same cycle as a request must win over the accept
        @(negedge clk);
        in_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk);
        #1 in_valid_i = 1'b0; flush_i = 1'b0;
        #1;
        n_total++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0)
            $display("FAIL flush_priority got=%b/%b want=1/0", in_ready_o, out_valid_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        operand_i = 32'hFFFF_FFFF; signed_i = 1'b0; rnd_i = 3'd0; out_ready_i = 1'b1;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if (in_ready_o !== 1'b0 || out_valid_o !== 1'b0 || result_o !== 32'd0 ||
            flags_o !== 5'd0)
            $display("FAIL reset_mid got=%b/%b/%h/%b want=0/0/00000000/00000", in_ready_o,
                     out_valid_o, result_o, flags_o);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 if (out_valid_o || result_o !== 32'd0) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL reset_mid_no_result got=%0d want=0", seen);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_one();
        test_signed();
        test_unsigned();
        test_rounding();
        test_dyn_and_special();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
